writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Registered, parametrised writeback stage between the memory stage and the register-file write port.
- Selects the writeback source: ALU result, load data, carry-out word, or forwarded result.
- Holds a load whose memory data returns late, with a timeout, and controls the register-file write enable.
- Adds flush/stall handling, a write-retire counter and an error flag.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, destination register index width.
- TIMEOUT, 15, maximum cycles spent waiting for late load data before the entry is dropped.
- CNT_W, 16, width of the retire counter.
- ZERO_REG, 1, when 1 a write to register index 0 is suppressed.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  kill the staged entry and any pending load; write enable forced 0 this cycle.
- stall_i  in  1  blocks acceptance of new entries.
- valid_i  in  1  upstream entry present.
- ready_o  out  1  stage can accept an entry this cycle.
- reg_write_enable_i  in  1  entry writes the register file.
- rd_i  in  ADDR_W  destination index.
- wb_sel_i  in  2  source: 00 result, 01 mem, 10 cout, 11 forward-or-result.
- result_i, cout_i, forward_data_i  in  DATA_W each  data sources.
- forward_en_i  in  1  when wb_sel_i=11, selects forward_data_i, otherwise result_i.
- mem_data_i  in  DATA_W  load data.
- mem_valid_i  in  1  mem_data_i valid this cycle.
- reg_write_enable_o  out  1  register-file write strobe, one cycle per entry.
- reg_write_addr_o  out  ADDR_W  register-file write index.
- reg_write_data_o  out  DATA_W  register-file write data.
- retire_count_o  out  CNT_W  number of completed writes.
- timeout_err_o  out  1  sticky error: a load was dropped on timeout.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE.
  - reg_write_enable_o=0, reg_write_addr_o=0, reg_write_data_o=0.
  - retire_count_o=0, timeout_err_o=0, wait counter=0.
- States: IDLE, WAIT_MEM.
- ready_o = (state==IDLE) & ~stall_i & ~flush_i.
- Accept = valid_i & ready_o. Source mux is evaluated on the inputs at accept.
- IDLE, accept with wb_sel_i != 01, or with wb_sel_i=01 and mem_valid_i=1:
  - Next cycle: output registers load addr and selected data.
  - Write strobe = reg_write_enable_i & ~(ZERO_REG & rd_i==0).
  - Latency: exactly 1 cycle from accept to strobe.
- IDLE, accept with wb_sel_i=01 and mem_valid_i=0:
  - Capture rd_i and enable; go to WAIT_MEM; wait counter=0; strobe stays 0.
- WAIT_MEM behaviour:
  - Each cycle without mem_valid_i the counter increments.
  - mem_valid_i=1 loads mem_data_i; the strobe fires next cycle; next state IDLE.
  - Counter reaching TIMEOUT without mem_valid_i: drop the entry, no strobe, set timeout_err_o, return to IDLE.
  - mem_valid_i on the same cycle the counter reaches TIMEOUT: the data wins and no error is raised.
- reg_write_enable_o is a registered one-cycle pulse.
  - It is gated combinationally by flush_i: reg_write_enable_o = strobe_q & ~flush_i.
  - A flushed strobe is lost and not counted.
  - Addr/data outputs hold their last value when no strobe is active.
- flush_i in WAIT_MEM: return to IDLE, discard pending entry, clear counter; no error raised.
- stall_i does not affect an already staged strobe or a WAIT_MEM entry; it only blocks accept.
- retire_count_o increments on every visible reg_write_enable_o=1 and wraps from 2^CNT_W-1 to 0.
- timeout_err_o is cleared only by reset.
- Reset mid-WAIT_MEM: entry discarded, all outputs take their reset values.

Test Plan:
- Reset, then accept rd=3, sel=00, result=0x1234 -> next cycle enable=1, addr=3, data=0x1234; retire_count=1; enable=0 the following cycle.
- sel=11, forward_en=1, forward=0xBEEF, result=0x1111 -> data=0xBEEF; with forward_en=0 -> data=0x1111.
- sel=01, mem_valid_i=0 at accept, mem_valid_i=1 with data 0xCAFE three cycles later:
  - ready_o=0 while waiting.
  - enable=1, data=0xCAFE one cycle after mem_valid_i.
- TIMEOUT=4, load never returns -> no strobe, timeout_err_o=1 after 4 wait cycles, ready_o=1 again, retire_count unchanged.
- rd=0 with ZERO_REG=1 -> no strobe, count unchanged. Strobe cycle with flush_i=1 -> enable=0, count unchanged. flush_i during WAIT_MEM -> state IDLE, no error.
- Set retire_count to 0xFFFF via 65535 writes, then one more write -> retire_count_o=0. Reset asserted during WAIT_MEM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/writeback_stage.sv
// Writeback stage: picks the writeback source, holds a late load with a
// bounded wait, and drives the register-file write port with a one-cycle
// strobe. Also keeps a count of retired writes and a sticky timeout flag.
module writeback_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              reg_write_enable_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] cout_i,
  input  logic [DATA_W-1:0] forward_data_i,
  input  logic              forward_en_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_valid_i,
  output logic              reg_write_enable_o,
  output logic [ADDR_W-1:0] reg_write_addr_o,
  output logic [DATA_W-1:0] reg_write_data_o,
  output logic [CNT_W-1:0]  retire_count_o,
  output logic              timeout_err_o
);

  localparam int WCNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT);

  typedef enum logic [0:0] {IDLE, WAIT_MEM} state_t;

  state_t              state_p1, state_nxt;
  logic [WCNT_W-1:0]   wcnt_p1, wcnt_nxt, wcnt_inc;
  logic [ADDR_W-1:0]   pend_rd_p1, pend_rd_nxt;
  logic                pend_we_p1, pend_we_nxt;
  logic                strobe_p1, strobe_nxt;
  logic [ADDR_W-1:0]   addr_p1, addr_nxt;
  logic [DATA_W-1:0]   data_p1, data_nxt;
  logic                err_p1, err_nxt;
  logic [CNT_W-1:0]    retire_p1;
  logic                accept;

  // Writeback source mux; selector 11 falls back to the ALU result unless
  // forwarding is enabled.
  function automatic logic [DATA_W-1:0] select_src(
    input logic [1:0]        sel,
    input logic              fwd_en,
    input logic [DATA_W-1:0] res,
    input logic [DATA_W-1:0] mem,
    input logic [DATA_W-1:0] cout,
    input logic [DATA_W-1:0] fwd
  );
    case (sel)
      2'b00:   select_src = res;
      2'b01:   select_src = mem;
      2'b10:   select_src = cout;
      default: select_src = fwd_en ? fwd : res;
    endcase
  endfunction

  // Writes to the hardwired zero register are dropped when enabled.
  function automatic logic is_zero_dst(input logic [ADDR_W-1:0] rd);
    is_zero_dst = (ZERO_REG != 0) && (rd == '0);
  endfunction

  assign ready_o  = (state_p1 == IDLE) && !stall_i && !flush_i;
  assign accept   = valid_i && ready_o;
  assign wcnt_inc = wcnt_p1 + 1'b1;

  // Next-state and next-output computation for the accept / wait FSM.
  always_comb begin
    state_nxt   = state_p1;
    wcnt_nxt    = wcnt_p1;
    pend_rd_nxt = pend_rd_p1;
    pend_we_nxt = pend_we_p1;
    strobe_nxt  = 1'b0;
    addr_nxt    = addr_p1;
    data_nxt    = data_p1;
    err_nxt     = err_p1;
    case (state_p1)
      IDLE: begin
        if (accept) begin
          if (wb_sel_i == 2'b01 && !mem_valid_i) begin
            state_nxt   = WAIT_MEM;
            wcnt_nxt    = '0;
            pend_rd_nxt = rd_i;
            pend_we_nxt = reg_write_enable_i;
          end else begin
            strobe_nxt = reg_write_enable_i && !is_zero_dst(rd_i);
            if (strobe_nxt) begin
              addr_nxt = rd_i;
              data_nxt = select_src(wb_sel_i, forward_en_i, result_i,
                                    mem_data_i, cout_i, forward_data_i);
            end
          end
        end
      end
      WAIT_MEM: begin
        if (flush_i) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (mem_valid_i) begin
          // Returning data takes priority over a timeout on the same cycle.
          strobe_nxt = pend_we_p1 && !is_zero_dst(pend_rd_p1);
          if (strobe_nxt) begin
            addr_nxt = pend_rd_p1;
            data_nxt = mem_data_i;
          end
          state_nxt = IDLE;
          wcnt_nxt  = '0;
        end else if (wcnt_inc == TMO) begin
          state_nxt = IDLE;
          wcnt_nxt  = '0;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt = wcnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
      end
    endcase
  end

  // Stage p1 registers: FSM state, pending load, and the write-port outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_p1   <= IDLE;
      wcnt_p1    <= '0;
      pend_rd_p1 <= '0;
      pend_we_p1 <= 1'b0;
      strobe_p1  <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
      err_p1     <= 1'b0;
    end else begin
      state_p1   <= state_nxt;
      wcnt_p1    <= wcnt_nxt;
      pend_rd_p1 <= pend_rd_nxt;
      pend_we_p1 <= pend_we_nxt;
      strobe_p1  <= strobe_nxt;
      addr_p1    <= addr_nxt;
      data_p1    <= data_nxt;
      err_p1     <= err_nxt;
    end
  end

  // Retire counter advances only on strobes that survive the flush gate.
  always_ff @(posedge clk_i) begin
    if (rst_i) retire_p1 <= '0;
    else if (reg_write_enable_o) retire_p1 <= retire_p1 + 1'b1;
  end

  assign reg_write_enable_o = strobe_p1 && !flush_i;
  assign reg_write_addr_o   = addr_p1;
  assign reg_write_data_o   = data_p1;
  assign retire_count_o     = retire_p1;
  assign timeout_err_o      = err_p1;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage with a short load timeout.
`timescale 1ns/1ps
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, stall_i, valid_i, ready_o;
  logic        reg_write_enable_i, forward_en_i, mem_valid_i;
  logic [4:0]  rd_i;
  logic [1:0]  wb_sel_i;
  logic [31:0] result_i, cout_i, forward_data_i, mem_data_i;
  logic        reg_write_enable_o, timeout_err_o;
  logic [4:0]  reg_write_addr_o;
  logic [31:0] reg_write_data_o;
  logic [15:0] retire_count_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_cnt;

  writeback_stage #(.DATA_W(32), .ADDR_W(5), .TIMEOUT(4), .CNT_W(16), .ZERO_REG(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .reg_write_enable_i(reg_write_enable_i), .rd_i(rd_i), .wb_sel_i(wb_sel_i),
    .result_i(result_i), .cout_i(cout_i), .forward_data_i(forward_data_i),
    .forward_en_i(forward_en_i), .mem_data_i(mem_data_i), .mem_valid_i(mem_valid_i),
    .reg_write_enable_o(reg_write_enable_o), .reg_write_addr_o(reg_write_addr_o),
    .reg_write_data_o(reg_write_data_o), .retire_count_o(retire_count_o),
    .timeout_err_o(timeout_err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic [4:0] rd, input logic we);
    valid_i = 1'b1; wb_sel_i = sel; rd_i = rd; reg_write_enable_i = we;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL reset_en got %0h want 0", reg_write_enable_o); end
    total++; if (reg_write_addr_o !== 5'd0) begin bad++; $display("FAIL reset_addr got %0h want 0", reg_write_addr_o); end
    total++; if (reg_write_data_o !== 32'd0) begin bad++; $display("FAIL reset_data got %0h want 0", reg_write_data_o); end
    total++; if (retire_count_o !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0h want 0", retire_count_o); end
    total++; if (timeout_err_o !== 1'b0) begin bad++; $display("FAIL reset_err got %0h want 0", timeout_err_o); end
    exp_cnt = 16'd0;
  endtask

  task automatic test_result();
    result_i = 32'h1234; drive(2'b00, 5'd3, 1'b1); #1;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL idle_ready got %0h want 1", ready_o); end
    tick(); valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b1) begin bad++; $display("FAIL res_en got %0h want 1", reg_write_enable_o); end
    total++; if (reg_write_addr_o !== 5'd3) begin bad++; $display("FAIL res_addr got %0h want 3", reg_write_addr_o); end
    total++; if (reg_write_data_o !== 32'h1234) begin bad++; $display("FAIL res_data got %0h want 1234", reg_write_data_o); end
    tick(); exp_cnt = 16'd1;
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL res_en_pulse got %0h want 0", reg_write_enable_o); end
    total++; if (retire_count_o !== exp_cnt) begin bad++; $display("FAIL res_cnt got %0h want %0h", retire_count_o, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    result_i = 32'h1111; forward_data_i = 32'hBEEF; cout_i = 32'h0C0C;
    forward_en_i = 1'b1; drive(2'b11, 5'd4, 1'b1);
    tick(); forward_en_i = 1'b0;
    total++; if (reg_write_data_o !== 32'hBEEF) begin bad++; $display("FAIL fwd_data got %0h want beef", reg_write_data_o); end
    tick(); drive(2'b10, 5'd6, 1'b1);
    total++; if (reg_write_data_o !== 32'h1111) begin bad++; $display("FAIL nofwd_data got %0h want 1111", reg_write_data_o); end
    total++; if (reg_write_enable_o !== 1'b1) begin bad++; $display("FAIL nofwd_en got %0h want 1", reg_write_enable_o); end
    tick(); valid_i = 1'b0;
    total++; if (reg_write_data_o !== 32'h0C0C || reg_write_addr_o !== 5'd6) begin bad++; $display("FAIL cout_data got %0h/%0h want c0c/6", reg_write_data_o, reg_write_addr_o); end
    tick(); exp_cnt = exp_cnt + 16'd3;
    total++; if (retire_count_o !== exp_cnt) begin bad++; $display("FAIL b2b_cnt got %0h want %0h", retire_count_o, exp_cnt); end
  endtask

  task automatic test_load();
    mem_data_i = 32'h5555; mem_valid_i = 1'b1; drive(2'b01, 5'd2, 1'b1);
    tick(); valid_i = 1'b0; mem_valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b1 || reg_write_data_o !== 32'h5555) begin bad++; $display("FAIL load_now got %0h/%0h want 1/5555", reg_write_enable_o, reg_write_data_o); end
    tick(); exp_cnt = exp_cnt + 16'd1;
    drive(2'b01, 5'd7, 1'b1);
    tick(); valid_i = 1'b0; #1;
    total++; if (ready_o !== 1'b0 || reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL wait_ready got %0h/%0h want 0/0", ready_o, reg_write_enable_o); end
    tick(); tick();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL wait_ready2 got %0h want 0", ready_o); end
    mem_valid_i = 1'b1; mem_data_i = 32'hCAFE;
    tick(); mem_valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b1 || reg_write_data_o !== 32'hCAFE || reg_write_addr_o !== 5'd7) begin bad++; $display("FAIL late_load got %0h/%0h/%0h want 1/cafe/7", reg_write_enable_o, reg_write_data_o, reg_write_addr_o); end
    tick(); exp_cnt = exp_cnt + 16'd1;
    total++; if (ready_o !== 1'b1 || retire_count_o !== exp_cnt) begin bad++; $display("FAIL late_done got %0h/%0h want 1/%0h", ready_o, retire_count_o, exp_cnt); end
  endtask

  task automatic test_timeout_race();
    drive(2'b01, 5'd8, 1'b1);
    tick(); valid_i = 1'b0;
    tick(); tick(); tick();
    mem_valid_i = 1'b1; mem_data_i = 32'hD00D;
    tick(); mem_valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b1 || reg_write_data_o !== 32'hD00D || timeout_err_o !== 1'b0) begin bad++; $display("FAIL race got %0h/%0h/%0h want 1/d00d/0", reg_write_enable_o, reg_write_data_o, timeout_err_o); end
    tick(); exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_flush_wait();
    drive(2'b01, 5'd9, 1'b1);
    tick(); valid_i = 1'b0;
    tick(); flush_i = 1'b1;
    tick(); flush_i = 1'b0; #1;
    total++; if (ready_o !== 1'b1 || timeout_err_o !== 1'b0) begin bad++; $display("FAIL flush_wait got %0h/%0h want 1/0", ready_o, timeout_err_o); end
    mem_valid_i = 1'b1; mem_data_i = 32'hBAD0;
    tick(); mem_valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL flush_discard got %0h want 0", reg_write_enable_o); end
  endtask

  task automatic test_zero_reg();
    result_i = 32'h7777; drive(2'b00, 5'd0, 1'b1);
    tick(); drive(2'b00, 5'd10, 1'b0);
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL zero_reg got %0h want 0", reg_write_enable_o); end
    tick(); valid_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL we_off got %0h want 0", reg_write_enable_o); end
    tick();
    total++; if (retire_count_o !== exp_cnt) begin bad++; $display("FAIL zero_cnt got %0h want %0h", retire_count_o, exp_cnt); end
  endtask

  task automatic test_flush_strobe();
    result_i = 32'h4242; drive(2'b00, 5'd11, 1'b1);
    tick(); valid_i = 1'b0; flush_i = 1'b1; #1;
    total++; if (reg_write_enable_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL flush_strobe got %0h/%0h want 0/0", reg_write_enable_o, ready_o); end
    tick(); flush_i = 1'b0;
    total++; if (retire_count_o !== exp_cnt) begin bad++; $display("FAIL flush_cnt got %0h want %0h", retire_count_o, exp_cnt); end
    stall_i = 1'b1; drive(2'b00, 5'd12, 1'b1); #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL stall_ready got %0h want 0", ready_o); end
    tick(); valid_i = 1'b0; stall_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL stall_block got %0h want 0", reg_write_enable_o); end
  endtask

  task automatic test_timeout();
    drive(2'b01, 5'd5, 1'b1);
    tick(); valid_i = 1'b0;
    tick(); tick(); tick();
    total++; if (timeout_err_o !== 1'b0 || ready_o !== 1'b0) begin bad++; $display("FAIL tmo_early got %0h/%0h want 0/0", timeout_err_o, ready_o); end
    tick();
    total++; if (timeout_err_o !== 1'b1 || ready_o !== 1'b1 || reg_write_enable_o !== 1'b0) begin bad++; $display("FAIL tmo got %0h/%0h/%0h want 1/1/0", timeout_err_o, ready_o, reg_write_enable_o); end
    tick();
    total++; if (retire_count_o !== exp_cnt || timeout_err_o !== 1'b1) begin bad++; $display("FAIL tmo_sticky got %0h/%0h want %0h/1", retire_count_o, timeout_err_o, exp_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    drive(2'b01, 5'd13, 1'b1);
    tick(); valid_i = 1'b0;
    tick(); rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    total++; if (reg_write_enable_o !== 1'b0 || reg_write_addr_o !== 5'd0 || reg_write_data_o !== 32'd0 || retire_count_o !== 16'd0 || timeout_err_o !== 1'b0) begin bad++; $display("FAIL rst_wait got %0h/%0h/%0h/%0h/%0h want all 0", reg_write_enable_o, reg_write_addr_o, reg_write_data_o, retire_count_o, timeout_err_o); end
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_wait_ready got %0h want 1", ready_o); end
  endtask

  task automatic test_wrap();
    result_i = 32'h1; drive(2'b00, 5'd1, 1'b1);
    for (int i = 0; i < 65535; i++) tick();
    valid_i = 1'b0;
    tick();
    total++; if (retire_count_o !== 16'hFFFF) begin bad++; $display("FAIL cnt_full got %0h want ffff", retire_count_o); end
    valid_i = 1'b1;
    tick(); valid_i = 1'b0;
    tick();
    total++; if (retire_count_o !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got %0h want 0", retire_count_o); end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; stall_i = 1'b0; valid_i = 1'b0;
    reg_write_enable_i = 1'b0; forward_en_i = 1'b0; mem_valid_i = 1'b0;
    rd_i = '0; wb_sel_i = '0; result_i = '0; cout_i = '0;
    forward_data_i = '0; mem_data_i = '0; exp_cnt = '0;
    test_reset();
    test_result();
    test_back_to_back();
    test_load();
    test_timeout_race();
    test_flush_wait();
    test_zero_reg();
    test_flush_strobe();
    test_timeout();
    test_reset_mid_wait();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
